// File: rtl/apb_pkg.sv
// Shared types and default constants for the arbitrated APB master.
package apb_pkg;

    // Transfer sequencing states of the APB master
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 16;

    // Even parity over a byte, for optional protection of small control fields
    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin requester selection: first active request at or above rr_ptr, with wrap.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            grant_valid_o
);

    logic          found_s;
    logic [IW-1:0] idx_s;
    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;

    // Walk the requesters starting at the pointer; the first active one wins
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        sum_s   = '0;
        cand_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum_s = {1'b0, rr_ptr_i} + (IW+1)'(i);
            if (sum_s >= (IW+1)'(NREQ)) begin
                sum_s = sum_s - (IW+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IW-1:0];
            if (!found_s && req_i[cand_s]) begin
                found_s = 1'b1;
                idx_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Expand the winning index into a one-hot grant
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = idx_s;
        grant_valid_o = found_s;
        if (found_s) begin
            grant_o[idx_s] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by NREQ requesters through a round-robin arbiter,
// with a per-transfer wait-state timeout.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ-1:0]  req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  rsp_valid,
    output logic             rsp_err,
    output logic [DW-1:0]    rsp_rdata,
    output logic             psel,
    output logic             penable,
    output logic             pwrite,
    output logic [AW-1:0]    paddr,
    output logic [DW-1:0]    pwdata,
    input  logic [DW-1:0]    prdata,
    input  logic             pready
);

    localparam int         IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    apb_state_e      state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   owner_q;
    logic [7:0]      wait_q;
    logic            psel_q;
    logic            penable_q;
    logic            pwrite_q;
    logic [AW-1:0]   paddr_q;
    logic [DW-1:0]   pwdata_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic            rsp_err_q;
    logic [DW-1:0]   rsp_rdata_q;

    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   grant_idx_s;
    logic            grant_valid_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;
    logic            sel_write_s;
    logic [IW-1:0]   next_ptr_d;

    apb_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i         (req_valid),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant_s),
        .grant_idx_o   (grant_idx_s),
        .grant_valid_o (grant_valid_s)
    );

    // Pick out the granted requester's fields and the pointer value after it
    always_comb begin
        sel_addr_s  = req_addr[int'(grant_idx_s)*AW +: AW];
        sel_wdata_s = req_wdata[int'(grant_idx_s)*DW +: DW];
        sel_write_s = req_write[grant_idx_s];
        if (int'(grant_idx_s) == NREQ - 1) begin
            next_ptr_d = '0;
        end else begin
            next_ptr_d = grant_idx_s + IW'(1);
        end
    end

    // Accept strobe exists only in an IDLE cycle outside reset
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && !preset) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Transfer sequencer: accept, SETUP, ACCESS with wait/timeout, response
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            wait_q      <= 8'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_s) begin
                        paddr_q  <= sel_addr_s;
                        pwdata_q <= sel_wdata_s;
                        pwrite_q <= sel_write_s;
                        owner_q  <= grant_idx_s;
                        rr_ptr_q <= next_ptr_d;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_q    <= 8'd0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel_q               <= 1'b0;
                        penable_q            <= 1'b0;
                        rsp_valid_q[owner_q] <= 1'b1;
                        rsp_err_q            <= 1'b0;
                        rsp_rdata_q          <= pwrite_q ? '0 : prdata;
                        state_q              <= IDLE;
                    end else if (wait_q == WAIT_LAST) begin
                        psel_q               <= 1'b0;
                        penable_q            <= 1'b0;
                        rsp_valid_q[owner_q] <= 1'b1;
                        rsp_err_q            <= 1'b1;
                        rsp_rdata_q          <= '0;
                        state_q              <= IDLE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter NREQ, default 2, number of requesters (2..8).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 Parameter TIMEOUT, default 16, maximum ACCESS cycles before a transfer is aborted (2..255).
REQ-005 pclk  input  1  single clock; all logic on its rising edge.
REQ-006 preset  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  NREQ  per-requester transfer request.
REQ-008 req_ready  output  NREQ  per-requester accept strobe, at most one bit set.
REQ-009 req_write  input  NREQ  1 = write, 0 = read.
REQ-010 req_addr  input  NREQ*AW  per-requester address.
REQ-011 req_wdata  input  NREQ*DW  per-requester write data.
REQ-012 rsp_valid  output  NREQ  one-cycle completion pulse to the owning requester.
REQ-013 rsp_err  output  1  timeout flag, qualified by any rsp_valid bit.
REQ-014 rsp_rdata  output  DW  read data, qualified by any rsp_valid bit.
REQ-015 psel, penable, pwrite  output  1 each  APB master controls.
REQ-016 paddr  output  AW; pwdata  output  DW  APB address and write data.
REQ-017 prdata  input  DW; pready  input  1  APB slave returns; tie pready high for zero-wait slaves.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SETUP, ACCESS.
REQ-019 In IDLE with any req_valid set, the block SHALL grant round-robin, searching from index rr_ptr upward with wrap; req_ready[g] is combinational and high only in that IDLE cycle.
REQ-020 On accept, the block SHALL register paddr, pwrite and pwdata from requester g, store g, set rr_ptr = (g+1) mod NREQ, and go to SETUP.
REQ-021 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-022 ACCESS SHALL drive psel=1, penable=1 and hold paddr, pwrite and pwdata stable until exit.
REQ-023 In ACCESS with pready=1, the block SHALL, next edge, clear psel/penable, go to IDLE and pulse rsp_valid[g] with rsp_err=0; rsp_rdata = prdata for reads and 0 for writes.
REQ-024 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; when it equals TIMEOUT-1 with pready=0, the block SHALL exit as in REQ-023 but with rsp_err=1 and rsp_rdata=0.
REQ-025 Latency: accept at cycle T, psel high at T+1, penable high at T+2, rsp_valid at T+2+W+1 for W wait cycles. A new accept SHALL be possible in the rsp_valid cycle.
REQ-026 rsp_valid, rsp_err and rsp_rdata SHALL be registered; there is no response backpressure.
REQ-027 Dropping req_valid before req_ready is legal; no transfer occurs and rr_ptr is unchanged.
REQ-028 In IDLE, paddr, pwrite and pwdata SHALL hold their last values; psel=penable=0.

Reset
REQ-029 With preset high at an edge, the block SHALL set state=IDLE, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, rr_ptr=0 and wait counter=0.
REQ-030 A reset asserted mid-transfer SHALL abort it with no rsp_valid; req_ready SHALL be 0 while preset is high.

Structure
REQ-031 Package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the default AW/DW/TIMEOUT constants.
REQ-032 Round-robin grant logic SHALL be a sub-module apb_rr_arbiter (inputs: req vector, rr_ptr; output: one-hot grant plus index).

Verification
REQ-033 Single read: req_valid[0], addr 0x10, pready=1, prdata 0xCAFE -> req_ready[0] at T, psel at T+1, penable at T+2, rsp_valid[0] at T+3 with rsp_rdata 0xCAFE and rsp_err 0.
REQ-034 Contention: both req_valid held high for 4 transfers from reset -> grant order 0,1,0,1 with exactly one req_ready bit per accept.
REQ-035 Wait states: write to 0x20 with pready low for 3 ACCESS cycles -> penable high 4 cycles, pwdata stable, rsp_valid at T+6, rsp_rdata 0.
REQ-036 Timeout: TIMEOUT=4 with pready stuck low -> ACCESS lasts 4 cycles, then rsp_err=1, rsp_rdata=0, FSM back in IDLE.
REQ-037 Reset in ACCESS: preset high for one cycle -> psel/penable 0 next edge, no rsp_valid, next grant goes to requester 0.
